// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array load path: data width, spad limits,
// load-sequencer state encoding and cfg_mode encodings.
package pe_array_pkg;

  localparam int PE_DATA_W     = 16;
  localparam int PE_IF_DEPTH   = 12;
  localparam int PE_FILT_DEPTH = 224;

  localparam logic [1:0] MODE_START  = 2'b00;
  localparam logic [1:0] MODE_IFMAP  = 2'b01;
  localparam logic [1:0] MODE_FILTER = 2'b10;
  localparam logic [1:0] MODE_BOTH   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LD_IF = 3'd1,
    ST_GAP1  = 3'd2,
    ST_LD_F  = 3'd3,
    ST_GAP2  = 3'd4,
    ST_RUN   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/pe_load_addr_gen.sv
// GLB read address generator: loads a base and word count on start, then issues
// one read per cycle until the last word has been requested.
module pe_load_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  output logic              ren,
  output logic [ADDR_W-1:0] addr
);

  logic [CNT_W-1:0] remaining;
  logic             last;

  assign last = ren && (remaining == CNT_W'(1));

  // Address wraps modulo 2^ADDR_W by construction of the adder width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren       <= 1'b0;
      addr      <= '0;
      remaining <= '0;
    end else if (start) begin
      ren       <= (count != '0);
      addr      <= base;
      remaining <= count;
    end else if (ren) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - CNT_W'(1);
      if (last) ren <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_load_sequencer.sv
// PE load transmit sequencer: streams ifmap/filter words from GLB onto pe_data with
// load framing, then runs the PE until pe_complete. Option: PE_LOADSEQ_PERF_EN adds perf_stall.
module pe_load_sequencer
  import pe_array_pkg::*;
#(
  parameter int DATA_W     = PE_DATA_W,
  parameter int ADDR_W     = 16,
  parameter int IF_DEPTH   = PE_IF_DEPTH,
  parameter int FILT_DEPTH = PE_FILT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [3:0]        cfg_S,
  input  logic [4:0]        cfg_P,
  input  logic [3:0]        cfg_Q,
  input  logic [ADDR_W-1:0] cfg_if_base,
  input  logic [ADDR_W-1:0] cfg_f_base,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pe_data,
  output logic              pe_load,
  output logic              pe_load2,
  output logic              pe_load3,
  output logic              pe_start,
  input  logic              pe_complete,
  output logic              cfg_err,
  output logic              done
`ifdef PE_LOADSEQ_PERF_EN
  ,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [10:0] IF_LIM   = 11'(IF_DEPTH);
  localparam logic [10:0] FILT_LIM = 11'(FILT_DEPTH);

  seq_state_t        state, next_state;
  logic [1:0]        mode_q;
  logic [10:0]       n_f_q;
  logic [ADDR_W-1:0] f_base_q;
  logic              ren_d1;
  logic              complete_d;

  logic [7:0]        n_if;
  logic [10:0]       n_f;
  logic              accept, cfg_bad, ld_done, complete_rise;
  logic              ag_start;
  logic [ADDR_W-1:0] ag_base;
  logic [10:0]       ag_n;

  assign cfg_ready = (state == ST_IDLE);
  assign pe_start  = (state == ST_RUN);

  always_comb begin
    n_if          = 8'(cfg_S) * 8'(cfg_Q);
    n_f           = 11'(cfg_S) * 11'(cfg_P) * 11'(cfg_Q);
    accept        = cfg_valid && cfg_ready;
    cfg_bad       = (cfg_S == '0) || (cfg_P == '0) || (cfg_Q == '0)
                  || (cfg_mode[0] && ({3'b000, n_if} > IF_LIM))
                  || (cfg_mode[1] && (n_f > FILT_LIM));
    // A load phase ends once every read is issued and the final word is on pe_data.
    ld_done       = !mem_ren && !ren_d1 && pe_load;
    complete_rise = pe_complete && !complete_d;
  end

  always_comb begin
    next_state = state;
    ag_start   = 1'b0;
    ag_base    = f_base_q;
    ag_n       = n_f_q;
    case (state)
      ST_IDLE: begin
        if (accept && !cfg_bad) begin
          if (cfg_mode[0]) begin
            next_state = ST_LD_IF;
            ag_start   = 1'b1;
            ag_base    = cfg_if_base;
            ag_n       = {3'b000, n_if};
          end else if (cfg_mode[1]) begin
            next_state = ST_LD_F;
            ag_start   = 1'b1;
            ag_base    = cfg_f_base;
            ag_n       = n_f;
          end else begin
            next_state = ST_RUN;
          end
        end
      end
      ST_LD_IF: if (ld_done) next_state = ST_GAP1;
      ST_GAP1: begin
        if (mode_q[1]) begin
          next_state = ST_LD_F;
          ag_start   = 1'b1;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_LD_F:  if (ld_done) next_state = ST_GAP2;
      ST_GAP2:  next_state = ST_RUN;
      ST_RUN:   if (complete_rise) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      n_f_q      <= '0;
      f_base_q   <= '0;
      cfg_err    <= 1'b0;
      ren_d1     <= 1'b0;
      pe_data    <= '0;
      pe_load    <= 1'b0;
      pe_load2   <= 1'b0;
      pe_load3   <= 1'b0;
      complete_d <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      if (accept && !cfg_bad) begin
        mode_q   <= cfg_mode;
        n_f_q    <= n_f;
        f_base_q <= cfg_f_base;
      end
      cfg_err    <= accept && cfg_bad;
      ren_d1     <= mem_ren;
      if (ren_d1) pe_data <= mem_rdata;
      pe_load    <= ren_d1;
      pe_load2   <= ren_d1 && (state == ST_LD_IF);
      pe_load3   <= ren_d1 && (state == ST_LD_F);
      complete_d <= pe_complete;
      done       <= (state == ST_RUN) && complete_rise;
    end
  end

  pe_load_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (11)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ag_start),
    .base  (ag_base),
    .count (ag_n),
    .ren   (mem_ren),
    .addr  (mem_addr)
  );

`ifdef PE_LOADSEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_stall <= '0;
    else if ((state == ST_RUN) && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Scoreboard bench for pe_load_sequencer: stimulus queues expected reads, words and
// err/done events; a negedge monitor pops and compares whatever the DUT presents.
module tb_pe_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_mode = '0;
  logic [3:0]  cfg_S = '0;
  logic [4:0]  cfg_P = '0;
  logic [3:0]  cfg_Q = '0;
  logic [15:0] cfg_if_base = '0;
  logic [15:0] cfg_f_base = '0;
  logic        mem_ren;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] pe_data;
  logic        pe_load, pe_load2, pe_load3, pe_start;
  logic        pe_complete = 1'b0;
  logic        cfg_err, done;
`ifdef PE_LOADSEQ_PERF_EN
  logic [31:0] perf_stall;
`endif

  pe_load_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_S       (cfg_S),
    .cfg_P       (cfg_P),
    .cfg_Q       (cfg_Q),
    .cfg_if_base (cfg_if_base),
    .cfg_f_base  (cfg_f_base),
    .mem_ren     (mem_ren),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .pe_data     (pe_data),
    .pe_load     (pe_load),
    .pe_load2    (pe_load2),
    .pe_load3    (pe_load3),
    .pe_start    (pe_start),
    .pe_complete (pe_complete),
    .cfg_err     (cfg_err),
    .done        (done)
`ifdef PE_LOADSEQ_PERF_EN
    ,
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A3C;
  endfunction

  // SRAM model with one cycle of read latency.
  always @(posedge clk) if (mem_ren) mem_rdata <= word_at(mem_addr);

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] exp_addr_q[$];
  logic [17:0] exp_word_q[$];
  int          ren_cyc_q[$];
  int          exp_evt_q[$];
  int          passed = 0;
  int          total = 0;
  int          cnt_l2 = 0;
  int          cnt_l3 = 0;
  logic        prev_load = 1'b0;
  logic [1:0]  prev_qual = 2'b00;

  localparam int EVT_ERR  = 1;
  localparam int EVT_DONE = 2;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_load = 1'b0;
      prev_qual = 2'b00;
    end else begin
      if (mem_ren) begin
        if (exp_addr_q.size() == 0) check_output("unexpected_ren", {31'b0, mem_ren}, 32'd0);
        else check_output("mem_addr", {16'b0, mem_addr}, {16'b0, exp_addr_q.pop_front()});
        ren_cyc_q.push_back(cyc);
      end
      if (pe_load) begin
        if (exp_word_q.size() == 0) check_output("unexpected_load", {31'b0, pe_load}, 32'd0);
        else check_output("pe_word", {14'b0, pe_load2, pe_load3, pe_data}, {14'b0, exp_word_q.pop_front()});
        if (ren_cyc_q.size() == 0) check_output("load_without_ren", {31'b0, pe_load}, 32'd0);
        else check_output("load_latency", cyc - ren_cyc_q.pop_front(), 32'd2);
        check_output("one_qualifier", {31'b0, pe_load2 ^ pe_load3}, 32'd1);
        if (prev_load) check_output("frame_no_gap", {30'b0, pe_load2, pe_load3}, {30'b0, prev_qual});
        if (pe_load2) cnt_l2++;
        if (pe_load3) cnt_l3++;
      end else if (pe_load2 || pe_load3) begin
        check_output("qual_without_load", {30'b0, pe_load2, pe_load3}, 32'd0);
      end
      if (cfg_err) begin
        if (exp_evt_q.size() == 0) check_output("unexpected_cfg_err", {31'b0, cfg_err}, 32'd0);
        else check_output("evt_cfg_err", EVT_ERR, exp_evt_q.pop_front());
      end
      if (done) begin
        if (exp_evt_q.size() == 0) check_output("unexpected_done", {31'b0, done}, 32'd0);
        else check_output("evt_done", EVT_DONE, exp_evt_q.pop_front());
      end
      prev_load = pe_load;
      prev_qual = {pe_load2, pe_load3};
    end
  end

  task automatic apply_stimulus(input logic [1:0] mode, input logic [3:0] s, input logic [4:0] p,
                                input logic [3:0] q, input logic [15:0] ifb, input logic [15:0] fb,
                                input bit expect_err);
    int k;
    if (expect_err) begin
      exp_evt_q.push_back(EVT_ERR);
    end else begin
      if (mode[0])
        for (int i = 0; i < int'(s) * int'(q); i++) begin
          exp_addr_q.push_back(ifb + 16'(i));
          exp_word_q.push_back({2'b10, word_at(ifb + 16'(i))});
        end
      if (mode[1])
        for (int i = 0; i < int'(s) * int'(p) * int'(q); i++) begin
          exp_addr_q.push_back(fb + 16'(i));
          exp_word_q.push_back({2'b01, word_at(fb + 16'(i))});
        end
    end
    for (k = 0; k < 2000 && !cfg_ready; k++) begin
      @(posedge clk); #1;
    end
    check_output("ready_before_cfg", {31'b0, cfg_ready}, 32'd1);
    cfg_mode = mode; cfg_S = s; cfg_P = p; cfg_Q = q;
    cfg_if_base = ifb; cfg_f_base = fb;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic finish_job(input int delay);
    int k;
    for (k = 0; k < 2000 && !pe_start; k++) begin
      @(posedge clk); #1;
    end
    check_output("pe_start_high", {31'b0, pe_start}, 32'd1);
    check_output("ready_low_in_run", {31'b0, cfg_ready}, 32'd0);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    check_output("pe_start_held", {31'b0, pe_start}, 32'd1);
    exp_evt_q.push_back(EVT_DONE);
    pe_complete = 1'b1;
    @(posedge clk); #1;
    check_output("done_start_ready", {29'b0, done, pe_start, cfg_ready}, {29'b0, 3'b101});
    @(posedge clk); #1;
    check_output("done_one_cycle", {31'b0, done}, 32'd0);
    pe_complete = 1'b0;
    check_output("addr_q_drained", exp_addr_q.size(), 32'd0);
    check_output("word_q_drained", exp_word_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base2, base3, k;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_outputs",
      {24'b0, cfg_ready, mem_ren, pe_load, pe_load2, pe_load3, pe_start, cfg_err, done}, {24'b0, 8'h80});
    check_output("reset_pe_data", {16'b0, pe_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both phases: 3 ifmap words then 6 filter words.
    base2 = cnt_l2; base3 = cnt_l3;
    apply_stimulus(2'b11, 4'd3, 5'd2, 4'd1, 16'h0010, 16'h0040, 1'b0);
    finish_job(20);
    check_output("load2_count_3", cnt_l2 - base2, 32'd3);
    check_output("load3_count_6", cnt_l3 - base3, 32'd6);

    // Oversized ifmap, oversized filter and zero field all rejected.
    apply_stimulus(2'b01, 4'd4, 5'd1, 4'd4, 16'h0100, 16'h0200, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    check_output("ready_after_err", {31'b0, cfg_ready}, 32'd1);
    apply_stimulus(2'b10, 4'd12, 5'd24, 4'd4, 16'h0100, 16'h0200, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    apply_stimulus(2'b11, 4'd0, 5'd2, 4'd1, 16'h0100, 16'h0200, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    check_output("evt_q_after_errs", exp_evt_q.size(), 32'd0);

    // Filter at exactly FILT_DEPTH.
    base3 = cnt_l3;
    apply_stimulus(2'b10, 4'd7, 5'd8, 4'd4, 16'h0000, 16'h1000, 1'b0);
    finish_job(3);
    check_output("load3_count_224", cnt_l3 - base3, 32'd224);

    // Address wrap: FFFE, FFFF, 0000, 0001.
    base2 = cnt_l2;
    apply_stimulus(2'b01, 4'd4, 5'd1, 4'd1, 16'hFFFE, 16'h0000, 1'b0);
    finish_job(2);
    check_output("load2_count_wrap", cnt_l2 - base2, 32'd4);

    // Start-only job with pe_complete already high on RUN entry.
    pe_complete = 1'b1;
    apply_stimulus(2'b00, 4'd1, 5'd1, 4'd1, 16'h0000, 16'h0000, 1'b0);
    for (k = 0; k < 100 && !pe_start; k++) begin @(posedge clk); #1; end
    repeat (5) begin @(posedge clk); #1; end
    check_output("stale_complete_ignored", {30'b0, pe_start, done}, {30'b0, 2'b10});
    pe_complete = 1'b0;
    @(posedge clk); #1;
    finish_job(2);

    // Reset in the middle of the filter load.
    apply_stimulus(2'b11, 4'd2, 5'd3, 4'd2, 16'h0300, 16'h0400, 1'b0);
    for (k = 0; k < 200 && !pe_load3; k++) begin @(posedge clk); #1; end
    check_output("reached_ld_f", {31'b0, pe_load3}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_lines",
      {27'b0, pe_load, pe_load2, pe_load3, mem_ren, pe_start}, 32'd0);
    check_output("async_reset_ready", {31'b0, cfg_ready}, 32'd1);
    exp_addr_q.delete(); exp_word_q.delete(); ren_cyc_q.delete(); exp_evt_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base2 = cnt_l2; base3 = cnt_l3;
    apply_stimulus(2'b11, 4'd3, 5'd2, 4'd1, 16'h0010, 16'h0040, 1'b0);
    finish_job(5);
    check_output("post_reset_load2", cnt_l2 - base2, 32'd3);
    check_output("post_reset_load3", cnt_l3 - base3, 32'd6);
    check_output("final_evt_q", exp_evt_q.size(), 32'd0);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
